// File: rtl/rackbus_pkg.sv
// Shared types and constants for the SURF->TURFIO rackbus COUT receive path.
// Holds the aligner state encoding and the per-SURF COUT polarity maps.
package rackbus_pkg;

    localparam int RACKBUS_WORD_W = 6;
    localparam logic [RACKBUS_WORD_W-1:0] RACKBUS_TRAIN_PATTERN = 6'b011001;

    localparam int RACKBUS_NUM_SURF = 7;
    // Board-level swaps (COUT_INV) and SURF-side swaps (COUT_REMOTE_INV); XOR gives INV_DATA.
    localparam logic [RACKBUS_NUM_SURF-1:0] COUT_INV        = 7'b0000000;
    localparam logic [RACKBUS_NUM_SURF-1:0] COUT_REMOTE_INV = 7'b0000000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        HUNT   = 3'd2,
        VERIFY = 3'd3,
        LOCKED = 3'd4
    } aligner_state_t;

    function automatic logic cout_inv_for(input int surf);
        return COUT_INV[surf] ^ COUT_REMOTE_INV[surf];
    endfunction

endpackage

// File: rtl/rackbus_cout_aligner_if.sv
// Bus bundle between the COUT deserializer/command decoder and the word aligner.
// There is no handshake: raw_i is valid every clk; data_o is meaningful while data_valid_o is high.
interface rackbus_cout_aligner_if;
    import rackbus_pkg::*;

    logic [RACKBUS_WORD_W-1:0] raw_i;
    logic                      align_req_i;
    logic                      train_i;
    logic [RACKBUS_WORD_W-1:0] data_o;
    logic                      data_valid_o;
    logic                      locked_o;
    logic [2:0]                offset_o;
    logic                      align_fail_o;
    logic [15:0]               err_count_o;
    aligner_state_t            state_o;

    modport master (
        output raw_i, align_req_i, train_i,
        input  data_o, data_valid_o, locked_o, offset_o, align_fail_o, err_count_o, state_o
    );

    modport slave (
        input  raw_i, align_req_i, train_i,
        output data_o, data_valid_o, locked_o, offset_o, align_fail_o, err_count_o, state_o
    );

endinterface

// File: rtl/rackbus_barrel6.sv
// Registered 12-to-6 window select: polarity-corrected word into cur, cur into prev,
// and a registered window of {prev, cur} at the requested bit offset (2 clk latency).
module rackbus_barrel6
    import rackbus_pkg::*;
#(
    parameter logic INV_DATA = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [RACKBUS_WORD_W-1:0] raw_i,
    input  logic [2:0]                offset_i,
    output logic [RACKBUS_WORD_W-1:0] data_o
);

    logic [RACKBUS_WORD_W-1:0]   cur_q, prev_q, data_q;
    logic [RACKBUS_WORD_W-1:0]   window_d;
    logic [2*RACKBUS_WORD_W-1:0] cat;

    assign cat = {prev_q, cur_q};

    // Offset 0 selects cur; higher offsets pull older bits in from prev.
    always_comb begin
        window_d = cat[5:0];
        case (offset_i)
            3'd0:    window_d = cat[5:0];
            3'd1:    window_d = cat[6:1];
            3'd2:    window_d = cat[7:2];
            3'd3:    window_d = cat[8:3];
            3'd4:    window_d = cat[9:4];
            3'd5:    window_d = cat[10:5];
            default: window_d = cat[5:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q  <= '0;
            prev_q <= '0;
            data_q <= '0;
        end else begin
            cur_q  <= raw_i ^ {RACKBUS_WORD_W{INV_DATA}};
            prev_q <= cur_q;
            data_q <= window_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/rackbus_cout_aligner.sv
// COUT receive word aligner: hunts for the training word across barrel offsets, locks,
// then passes aligned words. Define RACKBUS_COUT_ERRCNT_EN to build the locked-error counter.
module rackbus_cout_aligner
    import rackbus_pkg::*;
#(
    parameter logic                      INV_DATA      = 1'b0,
    parameter logic [RACKBUS_WORD_W-1:0] TRAIN_PATTERN = RACKBUS_TRAIN_PATTERN,
    parameter int                        LOCK_COUNT    = 16,
    parameter int                        MAX_SWEEPS    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    rackbus_cout_aligner_if.slave  bus
);

    localparam logic [7:0] LOCK_N  = 8'(LOCK_COUNT);
    localparam logic [3:0] SWEEP_N = 4'(MAX_SWEEPS);

    aligner_state_t            state_q, state_d;
    logic [2:0]                offset_q, offset_d;
    logic [3:0]                sweeps_q, sweeps_d;
    logic [7:0]                matches_q, matches_d;
    logic                      settle_q, settle_d;
    logic                      locked_q, locked_d;
    logic                      fail_q, fail_d;
    logic [RACKBUS_WORD_W-1:0] data_w;
    logic [15:0]               err_w;
    logic                      match;
    logic                      advance;
    logic                      wrap;
    logic                      exhausted;
    logic [2:0]                next_offset;

    rackbus_barrel6 #(.INV_DATA(INV_DATA)) u_barrel (
        .clk      (clk),
        .rst      (rst),
        .raw_i    (bus.raw_i),
        .offset_i (offset_q),
        .data_o   (data_w)
    );

    assign match       = (data_w == TRAIN_PATTERN);
    assign wrap        = (offset_q == 3'd5);
    assign next_offset = wrap ? 3'd0 : offset_q + 3'd1;
    assign exhausted   = wrap && ((sweeps_q + 4'd1) == SWEEP_N);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            offset_q  <= '0;
            sweeps_q  <= '0;
            matches_q <= '0;
            settle_q  <= 1'b0;
            locked_q  <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            offset_q  <= offset_d;
            sweeps_q  <= sweeps_d;
            matches_q <= matches_d;
            settle_q  <= settle_d;
            locked_q  <= locked_d;
            fail_q    <= fail_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        sweeps_d  = sweeps_q;
        matches_d = matches_q;
        settle_d  = settle_q;
        locked_d  = locked_q;
        fail_d    = fail_q;
        advance   = 1'b0;
        // A restart request overrides whatever the hunt would have done this cycle.
        if (bus.align_req_i) begin
            state_d   = SETTLE;
            offset_d  = '0;
            sweeps_d  = '0;
            matches_d = '0;
            settle_d  = 1'b0;
            locked_d  = 1'b0;
            fail_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                SETTLE: begin
                    settle_d = ~settle_q;
                    if (settle_q) state_d = HUNT;
                end
                HUNT: begin
                    if (match) begin
                        state_d   = VERIFY;
                        matches_d = 8'd1;
                    end else begin
                        advance = 1'b1;
                    end
                end
                VERIFY: begin
                    if (match) begin
                        matches_d = matches_q + 8'd1;
                        if ((matches_q + 8'd1) == LOCK_N) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        matches_d = '0;
                        advance   = 1'b1;
                    end
                end
                LOCKED: ;
                default: state_d = IDLE;
            endcase
            // Step to the next offset; the last offset of the last sweep gives up.
            if (advance) begin
                settle_d = 1'b0;
                offset_d = next_offset;
                if (wrap) sweeps_d = sweeps_q + 4'd1;
                if (exhausted) begin
                    fail_d   = 1'b1;
                    offset_d = '0;
                    state_d  = IDLE;
                end else begin
                    state_d = SETTLE;
                end
            end
        end
    end

`ifdef RACKBUS_COUT_ERRCNT_EN
    logic [15:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (bus.align_req_i) begin
            err_d = '0;
        end else if ((state_q == LOCKED) && bus.train_i && !match && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= '0;
        else     err_q <= err_d;
    end

    assign err_w = err_q;
`else
    assign err_w = '0;
`endif

    always_comb begin
        bus.data_o       = data_w;
        bus.data_valid_o = locked_q;
        bus.locked_o     = locked_q;
        bus.offset_o     = offset_q;
        bus.align_fail_o = fail_q;
        bus.err_count_o  = err_w;
        bus.state_o      = state_q;
    end

endmodule
